// File: rtl/wfi_timeout_ctrl_pkg.sv
// rtl/wfi_timeout_ctrl_pkg.sv - shared types and constants for the WFI controller
//
// Purpose: WFI state encoding and privilege-mode constants used by
// wfi_timeout_ctrl.
package wfi_timeout_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    WAKE = 2'd2,
    TRAP = 2'd3
  } wfi_state_t;

  localparam logic [1:0] M_MODE = 2'b11;
  localparam logic [1:0] S_MODE = 2'b01;
  localparam logic [1:0] U_MODE = 2'b00;

endpackage

// File: rtl/wfi_timeout_ctrl_satcounter.sv
// rtl/wfi_timeout_ctrl_satcounter.sv - up counter with sync clear and optional saturation
//
// Purpose: W-bit counter. clr has priority over en. With SATURATE=1 the
// count holds at all-ones; with SATURATE=0 it wraps.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : clear count to 0 on the next edge
//   en         : increment on the next edge
//   count      : current count
module wfi_satcounter #(
  parameter int W        = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !(SATURATE && (&count_q))) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/wfi_timeout_ctrl.sv
// rtl/wfi_timeout_ctrl.sv - M-stage WFI controller with programmable timeout fault
//
// Purpose: holds the M stage while a WFI waits, wakes it when an interrupt
// becomes pending, and raises an illegal-instruction fault when an eligible
// wait reaches TimeoutLimit cycles.
// Optional feature macro: WFI_STALL_COUNT_EN (adds WfiStallCycles).
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   WfiM               : decoded legal WFI in M stage
//   FlushM             : M-stage flush, aborts the wait
//   InterruptPendingM  : any enabled interrupt pending
//   PrivilegeModeW     : current privilege mode
//   STATUS_TW          : mstatus.TW
//   TimeoutLimit       : wait cycles before the timeout fault
//   WfiStallM          : hold M stage
//   WfiWakeM           : one-cycle pulse, WFI retires normally
//   WfiTimeoutFaultM   : one-cycle pulse, raise illegal-instruction fault
//   WfiState           : current state for debug/coverage
//   WfiStallCycles     : (WFI_STALL_COUNT_EN) total stalled cycles, wrapping
module wfi_timeout_ctrl
  import wfi_timeout_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W   = 16,
  parameter bit S_SUPPORTED = 1'b1,
  parameter bit U_SUPPORTED = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 WfiM,
  input  logic                 FlushM,
  input  logic                 InterruptPendingM,
  input  logic [1:0]           PrivilegeModeW,
  input  logic                 STATUS_TW,
  input  logic [TIMEOUT_W-1:0] TimeoutLimit,
  output logic                 WfiStallM,
  output logic                 WfiWakeM,
  output logic                 WfiTimeoutFaultM,
  output logic [1:0]           WfiState
`ifdef WFI_STALL_COUNT_EN
  ,
  output logic [31:0]          WfiStallCycles
`endif
);

  wfi_state_t           state_q, state_d;
  logic                 eligible_q, eligible_d;
  logic                 eligible_now;
  logic                 go_wait;
  logic                 timeout_hit;
  logic [TIMEOUT_W-1:0] wait_cnt;

  assign eligible_now = U_SUPPORTED &&
                        ((STATUS_TW && (PrivilegeModeW != M_MODE)) ||
                         (S_SUPPORTED && (PrivilegeModeW == U_MODE)));

  // The counter holds 0 during the first WAIT cycle, so counter==limit-1
  // marks the limit-th WAIT cycle. A limit of 0 seen mid-wait never fires.
  assign timeout_hit = eligible_q && (TimeoutLimit != '0) &&
                       (wait_cnt == (TimeoutLimit - TIMEOUT_W'(1)));

  // Cleared outside WAIT so each wait starts from 0; saturates so a
  // mis-programmed limit below the count cannot fault after a wrap.
  wfi_satcounter #(
    .W       (TIMEOUT_W),
    .SATURATE(1'b1)
  ) u_wait_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  ((state_q != WAIT) || FlushM),
    .en   (state_q == WAIT),
    .count(wait_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      eligible_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      eligible_q <= eligible_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (WfiM && !FlushM) begin
          if (InterruptPendingM) begin
            state_d = WAKE;
          end else if (eligible_now && (TimeoutLimit == '0)) begin
            state_d = TRAP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (FlushM) begin
          state_d = IDLE;
        end else if (InterruptPendingM) begin
          state_d = WAKE;
        end else if (timeout_hit) begin
          state_d = TRAP;
        end
      end
      WAKE:    state_d = IDLE;
      TRAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign go_wait    = (state_q == IDLE) && (state_d == WAIT);
  assign eligible_d = go_wait ? eligible_now : eligible_q;

  always_comb begin
    WfiStallM        = 1'b0;
    WfiWakeM         = 1'b0;
    WfiTimeoutFaultM = 1'b0;
    case (state_q)
      IDLE:    WfiStallM = go_wait;  // stall already in the entry cycle
      WAIT:    WfiStallM = 1'b1;
      WAKE:    WfiWakeM = 1'b1;
      TRAP:    WfiTimeoutFaultM = 1'b1;
      default: ;
    endcase
  end

  assign WfiState = state_q;

`ifdef WFI_STALL_COUNT_EN
  wfi_satcounter #(
    .W       (32),
    .SATURATE(1'b0)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (1'b0),
    .en   (WfiStallM),
    .count(WfiStallCycles)
  );
`endif

endmodule

// File: doc/wfi_timeout_ctrl.md
Name: wfi_timeout_ctrl

Overview:
- Parametrised WFI controller for the M stage of the privileged unit.
- Holds the pipeline while a WFI waits for an interrupt and wakes it when one becomes pending.
- Raises an illegal-instruction fault when the wait reaches a run-time-programmable timeout in a trap-eligible mode.
- Supersedes the fixed power-of-two timeout bit with an explicit state machine, a programmable limit, a wake handshake and flush abort.

Parameters:
- TIMEOUT_W, 16, width of wait counter and of TimeoutLimit.
- S_SUPPORTED, 1, supervisor mode present; enables U-mode unconditional timeout.
- U_SUPPORTED, 1, user mode present; if 0, the timeout is never eligible.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- WfiM  in  1  decoded legal WFI in M stage
- FlushM  in  1  M-stage flush (trap/debug), aborts the wait
- InterruptPendingM  in  1  any enabled interrupt pending
- PrivilegeModeW  in  2  current privilege (11=M, 01=S, 00=U)
- STATUS_TW  in  1  mstatus.TW
- TimeoutLimit  in  TIMEOUT_W  cycles before timeout fault
- WfiStallM  out  1  hold M stage
- WfiWakeM  out  1  one-cycle pulse: WFI completes normally, retires
- WfiTimeoutFaultM  out  1  one-cycle pulse: raise illegal-instruction fault
- WfiState  out  2  current state, for debug/coverage

Behaviour:
- Reset: state IDLE, counter 0, Eligible latch 0; all outputs 0, WfiState=IDLE.
- Eligible = U_SUPPORTED & ((STATUS_TW & mode!=M) | (S_SUPPORTED & mode==U)).
- Eligible is latched on the IDLE->WAIT transition and is constant for that wait.
- States: IDLE, WAIT, WAKE, TRAP.
- IDLE:
  - WfiM & FlushM: stay IDLE, no outputs.
  - WfiM & InterruptPendingM: ->WAKE, no stall.
  - WfiM & Eligible & TimeoutLimit==0: ->TRAP.
  - Other WfiM: ->WAIT, counter cleared to 0, WfiStallM=1 combinationally in this entry cycle.
- WAIT: WfiStallM=1; counter increments each cycle, saturating at all-ones. Priority order:
  1. FlushM: ->IDLE, counter cleared.
  2. InterruptPendingM: ->WAKE. Wins over a timeout reached in the same cycle.
  3. Latched Eligible & counter==TimeoutLimit-1 (the TimeoutLimit-th WAIT cycle): ->TRAP.
- WAKE: WfiWakeM=1, WfiStallM=0, ->IDLE.
- TRAP: WfiTimeoutFaultM=1, WfiStallM=0, ->IDLE.
- Latency:
  - Interrupt pending while in WAIT -> WfiWakeM exactly 1 cycle later.
  - Fault pulse appears TimeoutLimit+1 cycles after the entry cycle.
- Not eligible: the wait never times out; only an interrupt or flush exits.
- TimeoutLimit is sampled live. A change during WAIT to a value <= counter is not caught until counter wraps; counter saturates, so no fault. Software must not do this.
- reset mid-WAIT: returns to IDLE same edge, no pulse emitted.
- WfiWakeM and WfiTimeoutFaultM are never both 1. No pulse is ever longer than 1 cycle.

Optional Feature:
- Macro: WFI_STALL_COUNT_EN.
- Defined: adds output WfiStallCycles (32-bit). It increments on every cycle WfiStallM=1, wraps at 2^32, and resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package (cvw), added there:
  - wfi_state_t enum (IDLE=0, WAIT=1, WAKE=2, TRAP=3).
  - Mode constants M_MODE=2'b11, S_MODE=2'b01, U_MODE=2'b00.
- One sub-module: wfi_satcounter, parametrised width, with synchronous clear, increment enable and saturate. Used for the wait counter; the stall-cycle counter uses it with saturation disabled.

Test Plan:
- U mode, S_SUPPORTED=1, TimeoutLimit=5, no interrupt, WfiM pulse -> WfiStallM high 6 cycles, then WfiTimeoutFaultM=1 for 1 cycle, WfiState back to IDLE.
- S mode, STATUS_TW=0, TimeoutLimit=3 -> stall persists past 100 cycles. InterruptPendingM raised at cycle 100 -> WfiWakeM=1 at cycle 101, no fault.
- M mode, STATUS_TW=1, TimeoutLimit=2 -> not eligible, no fault. Interrupt after 10 cycles -> wake.
- U mode, TimeoutLimit=4, InterruptPendingM asserted in the cycle counter==3 -> WfiWakeM=1, WfiTimeoutFaultM stays 0.
- Flush/reset abort:
  - FlushM in 3rd WAIT cycle -> IDLE next cycle, no pulses.
  - Separately, reset mid-WAIT -> all outputs 0.
  - Then new WfiM with TimeoutLimit=0 in U mode -> WfiTimeoutFaultM the next cycle, no stall.
- With WFI_STALL_COUNT_EN, two waits of 4 and 7 stalled cycles -> WfiStallCycles=11.
